// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Buffers a stream of complex samples in a DEPTH-entry FIFO and, whenever a
//   full frame of N samples is present and the FFT core is not busy, issues a
//   one-cycle start pulse followed by N back-to-back samples on the core's
//   data port. A one-cycle frame pulse marks the cycle after the last sample.
//
//   N and DEPTH must be powers of two, with N >= 4 and DEPTH >= N.
//
// Ports
//   clk, rstn              clock (rising edge), async active-low reset
//   s_valid_i/s_ready_o    upstream handshake; a write occurs when both are high
//   s_re_i, s_im_i         upstream sample (32-bit real / imaginary)
//   flush_i                synchronous clear of FIFO and state machine
//   fft_busy_i             FFT core busy; blocks the start of a new frame
//   start_o                frame-start pulse to the FFT core
//   dready_o               frame sample valid to the FFT core
//   x0_re_o, x0_im_o       frame sample, registered, held while dready_o is low
//   level_o                FIFO occupancy in samples
//   frame_o                pulse in the cycle after the last sample of a frame
module fft_input_loader #(
  parameter int N     = 256,
  parameter int DEPTH = 512,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid_i,
  input  logic [31:0]   s_re_i,
  input  logic [31:0]   s_im_i,
  output logic          s_ready_o,
  input  logic          flush_i,
  input  logic          fft_busy_i,
  output logic          start_o,
  output logic          dready_o,
  output logic [31:0]   x0_re_o,
  output logic [31:0]   x0_im_o,
  output logic [LW-1:0] level_o,
  output logic          frame_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dready_q, dready_d;
  logic          frame_q, frame_d;
  logic [31:0]   re_q, re_d;
  logic [31:0]   im_q, im_d;
  // Low during reset and for the first edge after release, so that s_ready_o
  // comes up on the first clock edge after rstn deasserts.
  logic          alive_q, alive_d;

  logic [63:0]   mem [DEPTH];
  logic [63:0]   rd_data;
  logic          wr_en;
  logic          rd_en;

  // Ready depends only on registered state and flush_i, never on s_valid_i.
  assign s_ready_o = alive_q & (level_q < LW'(DEPTH)) & ~flush_i;
  assign wr_en     = s_valid_i & s_ready_o;
  assign rd_data   = mem[rptr_q];

  assign start_o   = (state_q == START);
  assign dready_o  = dready_q;
  assign frame_o   = frame_q;
  assign x0_re_o   = re_q;
  assign x0_im_o   = im_q;
  assign level_o   = level_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = 1'b0;
    rd_en    = 1'b0;
    re_d     = re_q;
    im_d     = im_q;
    alive_d  = 1'b1;

    case (state_q)
      IDLE: begin
        // A start needs a whole frame already buffered, so the reads that
        // follow can never run the FIFO empty.
        if (level_q >= LW'(N) && !fft_busy_i) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        rd_en   = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        // cnt_q is the index of the sample currently on the output; the read
        // for sample k+1 is issued while sample k is presented.
        if (cnt_q == CW'(N - 1)) begin
          state_d = IDLE;
          frame_d = 1'b1;
        end else begin
          rd_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    dready_d = rd_en;
    if (rd_en) begin
      re_d = rd_data[63:32];
      im_d = rd_data[31:0];
    end

    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(rd_en);
    level_d = level_q + LW'(wr_en) - LW'(rd_en);

    // Flush wins over everything; the sample output registers keep their
    // last value, only the qualifiers drop.
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      wptr_d   = '0;
      rptr_d   = '0;
      level_d  = '0;
      dready_d = 1'b0;
      frame_d  = 1'b0;
      re_d     = re_q;
      im_d     = im_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      dready_q <= 1'b0;
      frame_q  <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      dready_q <= dready_d;
      frame_q  <= frame_d;
      re_q     <= re_d;
      im_q     <= im_d;
      alive_q  <= alive_d;
    end
  end

  // Sample storage has no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= {s_re_i, s_im_i};
  end

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;
  localparam int N     = 256;
  localparam int DEPTH = 512;
  localparam int LW    = 10;

  logic          clk;
  logic          rstn;
  logic          s_valid_i;
  logic [31:0]   s_re_i;
  logic [31:0]   s_im_i;
  logic          s_ready_o;
  logic          flush_i;
  logic          fft_busy_i;
  logic          start_o;
  logic          dready_o;
  logic [31:0]   x0_re_o;
  logic [31:0]   x0_im_o;
  logic [LW-1:0] level_o;
  logic          frame_o;

  fft_input_loader #(.N(N), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rstn(rstn), .s_valid_i(s_valid_i), .s_re_i(s_re_i),
    .s_im_i(s_im_i), .s_ready_o(s_ready_o), .flush_i(flush_i),
    .fft_busy_i(fft_busy_i), .start_o(start_o), .dready_o(dready_o),
    .x0_re_o(x0_re_o), .x0_im_o(x0_im_o), .level_o(level_o), .frame_o(frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc_n = 0, sent = 0, target = 0, run = 0;
  int frames = 0, starts = 0, st_last = -1000, st_prev = -1000, fr_last = 0;
  bit fired = 0, trunc = 0, lvl_var = 0, lvl_bad = 0;
  bit rnd_valid = 0, rnd_busy = 0;
  bit nx_rstn = 0, nx_flush = 0, nx_busy = 0;
  logic [LW-1:0] lvl0;
  logic [63:0]   exp_q [$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock: drive inputs just after the rising edge, observe outputs and
  // update the reference FIFO on the falling edge.
  task automatic cyc();
    @(posedge clk); #1;
    if (fired) sent++;
    fired      = 0;
    rstn       = nx_rstn;
    flush_i    = nx_flush;
    fft_busy_i = rnd_busy ? ($urandom_range(0, 3) == 0) : nx_busy;
    s_valid_i  = (sent < target) && (!rnd_valid || $urandom_range(0, 1) == 1);
    s_re_i     = 32'(sent);
    s_im_i     = 32'(-sent);
    @(negedge clk);
    cyc_n++;
    if (!rstn) trunc = 1;
    if (dready_o) begin
      if (run == 0) begin
        trunc = 0;
        lvl0  = level_o;
      end else if (level_o != lvl0) lvl_var = 1;
      chk("fifo_has_data", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("frame_data", {x0_re_o, x0_im_o}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      run++;
    end else if (run != 0) begin
      if (!trunc) chk("run_len", 64'(run), 64'(N));
      run = 0;
    end
    if (start_o) begin
      starts++;
      st_prev = st_last;
      st_last = cyc_n;
    end
    if (frame_o) begin
      frames++;
      fr_last = cyc_n;
      chk("frame_start_overlap", 64'(start_o), 64'd0);
    end
    if (flush_i) trunc = 1;
    if (!rstn || flush_i) exp_q.delete();
    else if (s_valid_i && s_ready_o) begin
      exp_q.push_back({s_re_i, s_im_i});
      fired = 1;
    end
  endtask

  initial begin
    int f0, s0, l0;
    rstn = 0; s_valid_i = 0; s_re_i = 0; s_im_i = 0; flush_i = 0; fft_busy_i = 0;

    // Reset state
    repeat (3) cyc();
    chk("rst_start", 64'(start_o), 64'd0);
    chk("rst_dready", 64'(dready_o), 64'd0);
    chk("rst_frame", 64'(frame_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_x0", {x0_re_o, x0_im_o}, 64'd0);
    chk("rst_ready", 64'(s_ready_o), 64'd0);
    nx_rstn = 1;
    cyc();
    chk("ready_before_edge", 64'(s_ready_o), 64'd0);
    cyc();
    chk("ready_after_edge", 64'(s_ready_o), 64'd1);

    // Basic frame
    f0 = frames; s0 = starts;
    target = sent + N;
    for (int i = 0; i < 800 && frames == f0; i++) cyc();
    chk("basic_frame_done", 64'(frames), 64'(f0 + 1));
    chk("basic_one_start", 64'(starts), 64'(s0 + 1));
    chk("basic_start_to_frame", 64'(fr_last - st_last), 64'(N + 1));
    chk("basic_level_end", 64'(level_o), 64'd0);

    // Busy hold
    nx_busy = 1;
    target = sent + N;
    for (int i = 0; i < 400 && level_o != LW'(N); i++) cyc();
    chk("busy_level_full", 64'(level_o), 64'(N));
    s0 = starts; lvl_bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (level_o != LW'(N)) lvl_bad = 1;
    end
    chk("busy_no_start", 64'(starts), 64'(s0));
    chk("busy_level_held", 64'(lvl_bad), 64'd0);
    nx_busy = 0;
    cyc();
    chk("busy_fall_no_start_yet", 64'(start_o), 64'd0);
    cyc();
    chk("busy_fall_start", 64'(start_o), 64'd1);
    f0 = frames;
    for (int i = 0; i < 400 && frames == f0; i++) cyc();
    chk("busy_frame_done", 64'(frames), 64'(f0 + 1));

    // Full FIFO
    nx_busy = 1;
    l0 = sent;
    target = sent + 520;
    repeat (560) cyc();
    chk("full_level", 64'(level_o), 64'(DEPTH));
    chk("full_not_ready", 64'(s_ready_o), 64'd0);
    chk("full_accepted", 64'(sent - l0), 64'(DEPTH));
    nx_busy = 0;
    f0 = frames;
    for (int i = 0; i < 1000 && frames != f0 + 2; i++) cyc();
    chk("full_two_frames", 64'(frames), 64'(f0 + 2));
    repeat (2) cyc();
    chk("full_leftover", 64'(level_o), 64'd8);
    nx_flush = 1; cyc();
    nx_flush = 0; cyc();
    chk("flush_idle_level", 64'(level_o), 64'd0);
    chk("flush_idle_ready", 64'(s_ready_o), 64'd1);

    // Concurrent write/read, back-to-back frames
    lvl_var = 0;
    f0 = frames;
    target = sent + 1100;
    for (int i = 0; i < 1500 && frames != f0 + 3; i++) cyc();
    chk("b2b_three_frames", 64'(frames), 64'(f0 + 3));
    chk("b2b_level_const", 64'(lvl_var), 64'd0);
    chk("b2b_spacing", 64'(st_last - st_prev), 64'(N + 2));
    target = sent;
    nx_flush = 1; cyc();
    nx_flush = 0; cyc();
    chk("b2b_flush_level", 64'(level_o), 64'd0);
    chk("b2b_flush_dready", 64'(dready_o), 64'd0);

    // Flush at frame sample 100
    target = sent + N;
    for (int i = 0; i < 700 && run != 100; i++) cyc();
    chk("reach_s100", 64'(run), 64'd100);
    f0 = frames;
    nx_flush = 1; cyc();
    nx_flush = 0; cyc();
    chk("flush_dready", 64'(dready_o), 64'd0);
    chk("flush_level", 64'(level_o), 64'd0);
    repeat (300) cyc();
    chk("flush_no_frame", 64'(frames), 64'(f0));

    // Reset at frame sample 50
    target = sent + N;
    for (int i = 0; i < 700 && run != 50; i++) cyc();
    chk("reach_s50", 64'(run), 64'd50);
    f0 = frames;
    nx_rstn = 0; cyc();
    chk("mrst_start", 64'(start_o), 64'd0);
    chk("mrst_dready", 64'(dready_o), 64'd0);
    chk("mrst_frame", 64'(frame_o), 64'd0);
    chk("mrst_level", 64'(level_o), 64'd0);
    chk("mrst_x0", {x0_re_o, x0_im_o}, 64'd0);
    chk("mrst_ready", 64'(s_ready_o), 64'd0);
    nx_rstn = 1;
    repeat (300) cyc();
    chk("mrst_no_frame", 64'(frames), 64'(f0));
    chk("mrst_level_after", 64'(level_o), 64'd0);

    // Pointer wrap with random valid/busy
    f0 = frames;
    target = sent + 3000;
    rnd_valid = 1; rnd_busy = 1;
    for (int i = 0; i < 20000 && sent < target; i++) cyc();
    chk("rand_all_sent", 64'(sent), 64'(target));
    rnd_valid = 0; rnd_busy = 0; nx_busy = 0;
    repeat (800) cyc();
    chk("rand_frames", 64'(frames - f0), 64'd11);
    chk("rand_level", 64'(level_o), 64'd184);
    chk("rand_model_level", 64'(exp_q.size()), 64'(level_o));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
